// File: rtl/multi_cycle_controller_if.sv
// Memory request handshake between the multi-cycle controller (master)
// and the shared instruction/data memory (slave).
interface multi_cycle_controller_if;
    logic mem_req;
    logic mem_write;
    logic adr_src;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_write,
        output adr_src,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_write,
        input  adr_src,
        output mem_ready
    );
endinterface

// File: rtl/multi_cycle_controller.sv
// Multi-cycle ARM control FSM: fetch/decode/execute/memory/writeback sequencing,
// condition evaluation against a registered NZCV, and a stallable memory handshake.
module multi_cycle_controller (
    input  logic                            clk,
    input  logic                            reset,
    multi_cycle_controller_if.master        mem,
    input  logic [31:0]                     instr,
    input  logic [3:0]                      alu_flags,
    output logic                            ir_write,
    output logic                            pc_write,
    output logic                            reg_write,
    output logic                            alu_src_a,
    output logic [1:0]                      alu_src_b,
    output logic [1:0]                      result_src,
    output logic [1:0]                      imm_src,
    output logic [1:0]                      reg_src,
    output logic [2:0]                      alu_ctl,
    output logic [3:0]                      flags,
    output logic                            instr_done
);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_ALU_WB,
        S_MEM_ADR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_flags;

    logic w_n, w_z, w_c, w_v;
    logic w_cond_pass;
    logic [2:0] w_dp_ctl;
    logic w_dp_supported;
    logic w_is_cmp;
    logic w_dp_writeback;
    logic w_rd_is_pc;
    logic w_flags_we;

    assign {w_n, w_z, w_c, w_v} = r_flags;

    always_comb begin
        case (instr[31:28])
            4'b0000: w_cond_pass = w_z;
            4'b0001: w_cond_pass = !w_z;
            4'b0010: w_cond_pass = w_c;
            4'b0011: w_cond_pass = !w_c;
            4'b0100: w_cond_pass = w_n;
            4'b0101: w_cond_pass = !w_n;
            4'b0110: w_cond_pass = w_v;
            4'b0111: w_cond_pass = !w_v;
            4'b1000: w_cond_pass = w_c && !w_z;
            4'b1001: w_cond_pass = !w_c || w_z;
            4'b1010: w_cond_pass = (w_n == w_v);
            4'b1011: w_cond_pass = (w_n != w_v);
            4'b1100: w_cond_pass = !w_z && (w_n == w_v);
            4'b1101: w_cond_pass = w_z || (w_n != w_v);
            4'b1110: w_cond_pass = 1'b1;
            default: w_cond_pass = 1'b0;
        endcase
    end

    always_comb begin
        w_dp_ctl       = ALU_ADD;
        w_dp_supported = 1'b1;
        case (instr[24:21])
            4'b0100: w_dp_ctl = ALU_ADD;
            4'b0010: w_dp_ctl = ALU_SUB;
            4'b0000: w_dp_ctl = ALU_AND;
            4'b1100: w_dp_ctl = ALU_ORR;
            4'b1010: w_dp_ctl = ALU_SUB;
            default: w_dp_supported = 1'b0;
        endcase
    end

    assign w_is_cmp       = (instr[24:21] == 4'b1010);
    assign w_dp_writeback = w_dp_supported && !w_is_cmp;
    assign w_rd_is_pc     = (instr[15:12] == 4'hF);
    assign w_flags_we     = (r_state == S_EXECUTE) && (instr[20] || w_is_cmp);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_flags <= 4'b0000;
        end else begin
            r_state <= w_state_next;
            if (w_flags_we) begin
                r_flags <= alu_flags;
            end
        end
    end

    // Ungated control values; every output is forced low while reset is high.
    logic       w_mem_req, w_mem_write, w_adr_src, w_ir_write, w_pc_write;
    logic       w_reg_write, w_alu_src_a, w_instr_done;
    logic [1:0] w_alu_src_b, w_result_src, w_imm_src, w_reg_src;
    logic [2:0] w_alu_ctl;

    always_comb begin
        w_state_next = r_state;
        w_mem_req    = 1'b0;
        w_mem_write  = 1'b0;
        w_adr_src    = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = 2'b00;
        w_result_src = 2'b00;
        w_imm_src    = 2'b00;
        w_reg_src    = 2'b00;
        w_alu_ctl    = ALU_ADD;
        w_instr_done = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                if (mem.mem_ready) begin
                    w_ir_write   = 1'b1;
                    w_pc_write   = 1'b1;
                    w_alu_src_a  = 1'b1;
                    w_alu_src_b  = 2'b10;
                    w_result_src = 2'b10;
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                if (!w_cond_pass || instr[27:26] == 2'b11) begin
                    w_instr_done = 1'b1;
                    w_state_next = S_FETCH;
                end else if (instr[27:26] == 2'b00) begin
                    w_state_next = S_EXECUTE;
                end else if (instr[27:26] == 2'b01) begin
                    w_state_next = S_MEM_ADR;
                end else begin
                    w_state_next = S_BRANCH;
                end
            end
            S_EXECUTE: begin
                w_alu_src_b  = instr[25] ? 2'b01 : 2'b00;
                w_alu_ctl    = w_dp_ctl;
                w_state_next = S_ALU_WB;
            end
            S_ALU_WB: begin
                w_pc_write   = w_dp_writeback && w_rd_is_pc;
                w_reg_write  = w_dp_writeback && !w_rd_is_pc;
                w_instr_done = 1'b1;
                w_state_next = S_FETCH;
            end
            S_MEM_ADR: begin
                w_alu_src_b  = 2'b01;
                w_imm_src    = 2'b01;
                w_alu_ctl    = instr[23] ? ALU_ADD : ALU_SUB;
                w_state_next = instr[20] ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                w_mem_req = 1'b1;
                w_adr_src = 1'b1;
                if (mem.mem_ready) begin
                    w_state_next = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                w_result_src = 2'b01;
                w_pc_write   = w_rd_is_pc;
                w_reg_write  = !w_rd_is_pc;
                w_instr_done = 1'b1;
                w_state_next = S_FETCH;
            end
            S_MEM_WR: begin
                w_mem_req   = 1'b1;
                w_mem_write = 1'b1;
                w_adr_src   = 1'b1;
                w_reg_src   = 2'b10;
                if (mem.mem_ready) begin
                    w_instr_done = 1'b1;
                    w_state_next = S_FETCH;
                end
            end
            S_BRANCH: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = 2'b01;
                w_imm_src    = 2'b10;
                w_result_src = 2'b10;
                w_pc_write   = 1'b1;
                w_instr_done = 1'b1;
                w_state_next = S_FETCH;
            end
            default: w_state_next = S_FETCH;
        endcase
    end

    assign mem.mem_req   = !reset && w_mem_req;
    assign mem.mem_write = !reset && w_mem_write;
    assign mem.adr_src   = !reset && w_adr_src;
    assign ir_write      = !reset && w_ir_write;
    assign pc_write      = !reset && w_pc_write;
    assign reg_write     = !reset && w_reg_write;
    assign alu_src_a     = !reset && w_alu_src_a;
    assign instr_done    = !reset && w_instr_done;
    assign alu_src_b     = reset ? 2'b00 : w_alu_src_b;
    assign result_src    = reset ? 2'b00 : w_result_src;
    assign imm_src       = reset ? 2'b00 : w_imm_src;
    assign reg_src       = reset ? 2'b00 : w_reg_src;
    assign alu_ctl       = reset ? 3'b000 : w_alu_ctl;
    assign flags         = reset ? 4'b0000 : r_flags;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Randomized bench: per-instruction cycle scripts derived from the controller's
// behaviour, compared against every DUT output on every cycle.
module tb_multi_cycle_controller;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] imm_src;
        logic [1:0] reg_src;
        logic [2:0] alu_ctl;
        logic [3:0] flags;
        logic       instr_done;
    } outs_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [3:0]  alu_flags;
    logic        ir_write, pc_write, reg_write, alu_src_a, instr_done;
    logic [1:0]  alu_src_b, result_src, imm_src, reg_src;
    logic [2:0]  alu_ctl;
    logic [3:0]  flags;

    multi_cycle_controller_if bus ();

    multi_cycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .mem        (bus.master),
        .instr      (instr),
        .alu_flags  (alu_flags),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .imm_src    (imm_src),
        .reg_src    (reg_src),
        .alu_ctl    (alu_ctl),
        .flags      (flags),
        .instr_done (instr_done)
    );

    always #5 clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] m_flags = 4'b0000;

    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !(cy && !z);
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return !(!z && (n == v));
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Drive one cycle's inputs, check every output mid-cycle, advance to the next cycle.
    task automatic step(input outs_t e, input logic rdy, input logic [3:0] af);
        outs_t a;
        bus.mem_ready = rdy;
        alu_flags     = af;
        @(negedge clk);
        a = '{bus.mem_req, bus.mem_write, bus.adr_src, ir_write, pc_write, reg_write,
              alu_src_a, alu_src_b, result_src, imm_src, reg_src, alu_ctl, flags, instr_done};
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL outputs t=%0t instr=%h actual=%h required=%h", $time, instr, a, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [3:0] r4();
        return 4'($urandom_range(15));
    endfunction

    function automatic logic r1();
        return 1'($urandom_range(1));
    endfunction

    function automatic outs_t blank();
        outs_t e;
        e = '0;
        e.flags = m_flags;
        return e;
    endfunction

    // Play one instruction: fst/mst are wait cycles in fetch and in the data access;
    // abort>=0 asserts reset in that wait cycle of a store.
    task automatic run_instr(input logic [31:0] ins, input int fst, input int mst,
                             input int abort, input logic [3:0] af_exec, output int cyc);
        outs_t      e;
        logic [3:0] cmd;
        bit         wb, rd_pc;
        cyc   = 0;
        instr = ins;
        cmd   = ins[24:21];
        rd_pc = (ins[15:12] == 4'hF);
        for (int k = 0; k <= fst; k++) begin
            e = blank();
            e.mem_req = 1'b1;
            if (k == fst) begin
                e.ir_write = 1'b1; e.pc_write = 1'b1; e.alu_src_a = 1'b1;
                e.alu_src_b = 2'b10; e.result_src = 2'b10;
            end
            step(e, k == fst, r4());
            cyc++;
        end
        e = blank();
        e.alu_src_a = 1'b1;
        e.alu_src_b = 2'b10;
        if (!cond_holds(ins[31:28], m_flags) || ins[27:26] == 2'b11) begin
            e.instr_done = 1'b1;
            step(e, r1(), r4());
            cyc++;
            return;
        end
        step(e, r1(), r4());
        cyc++;
        if (ins[27:26] == 2'b00) begin
            e = blank();
            e.alu_src_b = ins[25] ? 2'b01 : 2'b00;
            wb = 1'b1;
            case (cmd)
                4'b0100: e.alu_ctl = 3'b000;
                4'b0010: e.alu_ctl = 3'b001;
                4'b0000: e.alu_ctl = 3'b010;
                4'b1100: e.alu_ctl = 3'b011;
                4'b1010: begin e.alu_ctl = 3'b001; wb = 1'b0; end
                default: wb = 1'b0;
            endcase
            step(e, r1(), af_exec);
            cyc++;
            if (ins[20] || cmd == 4'b1010) m_flags = af_exec;
            e = blank();
            e.pc_write   = wb && rd_pc;
            e.reg_write  = wb && !rd_pc;
            e.instr_done = 1'b1;
            step(e, r1(), r4());
            cyc++;
        end else if (ins[27:26] == 2'b01) begin
            e = blank();
            e.alu_src_b = 2'b01;
            e.imm_src   = 2'b01;
            e.alu_ctl   = ins[23] ? 3'b000 : 3'b001;
            step(e, r1(), r4());
            cyc++;
            for (int k = 0; k <= mst; k++) begin
                if (!ins[20] && k == abort) begin
                    reset = 1'b1;
                    step('0, 1'b1, r4());
                    reset   = 1'b0;
                    m_flags = 4'b0000;
                    cyc++;
                    return;
                end
                e = blank();
                e.mem_req = 1'b1;
                e.adr_src = 1'b1;
                if (!ins[20]) begin
                    e.mem_write  = 1'b1;
                    e.reg_src    = 2'b10;
                    e.instr_done = (k == mst);
                end
                step(e, k == mst, r4());
                cyc++;
            end
            if (ins[20]) begin
                e = blank();
                e.result_src = 2'b01;
                e.pc_write   = rd_pc;
                e.reg_write  = !rd_pc;
                e.instr_done = 1'b1;
                step(e, r1(), r4());
                cyc++;
            end
        end else begin
            e = blank();
            e.alu_src_a = 1'b1; e.alu_src_b = 2'b01; e.imm_src = 2'b10;
            e.result_src = 2'b10; e.pc_write = 1'b1; e.instr_done = 1'b1;
            step(e, r1(), r4());
            cyc++;
        end
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        logic [3:0]  cmds [7];
        int          cls;
        cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010, 4'b0001, 4'b1101};
        w    = $urandom;
        cls  = $urandom_range(0, 9);
        w[31:28] = ($urandom_range(0, 2) == 0) ? r4() : 4'hE;
        if ($urandom_range(0, 5) == 0) w[15:12] = 4'hF;
        if (cls <= 3) begin
            w[27:26] = 2'b00;
            w[24:21] = cmds[$urandom_range(0, 6)];
        end else if (cls <= 5) begin
            w[27:26] = 2'b01;
        end else if (cls <= 7) begin
            w[27:26] = 2'b10;
        end else if (cls == 8) begin
            w[27:26] = 2'b11;
        end
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout_watchdog actual=running required=finished");
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin
        int c, fst, mst, abort;
        logic [31:0] w;
        reset         = 1'b1;
        instr         = 32'h0;
        alu_flags     = 4'h0;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step('0, 1'b1, r4());
        reset = 1'b0;

        run_instr(32'hE2821005, 0, 0, -1, r4(), c);     chk("add_cycles", c, 4);
        run_instr(32'hE2533001, 0, 0, -1, 4'b0100, c);  chk("subs_flags", int'(flags), 4);
        run_instr(32'h0A000001, 0, 0, -1, r4(), c);     chk("beq_taken_cycles", c, 3);
        run_instr(32'hE2533001, 0, 0, -1, 4'b0000, c);  chk("subs_clear_flags", int'(flags), 0);
        run_instr(32'h0A000001, 0, 0, -1, r4(), c);     chk("beq_skip_cycles", c, 2);
        run_instr(32'hE5910004, 0, 2, -1, r4(), c);     chk("ldr_stall_cycles", c, 7);
        run_instr(32'hE5810008, 0, 0, -1, r4(), c);     chk("str_cycles", c, 4);
        run_instr(32'hE1530004, 0, 0, -1, 4'b1001, c);  chk("cmp_cycles", c, 4);
        chk("cmp_flags", int'(flags), 9);
        run_instr(32'hE5810008, 0, 3, 1, r4(), c);      chk("str_abort_cycles", c, 5);
        chk("flags_after_abort", int'(flags), 0);
        run_instr(32'hF0000000, 0, 0, -1, r4(), c);     chk("never_cycles", c, 2);
        run_instr(32'hEC000000, 0, 0, -1, r4(), c);     chk("op11_cycles", c, 2);
        run_instr(32'hE2821005, 2, 0, -1, r4(), c);     chk("fetch_stall_cycles", c, 6);

        for (int i = 0; i < 400; i++) begin
            w     = gen_instr();
            fst   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            mst   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            abort = ($urandom_range(0, 15) == 0) ? $urandom_range(0, mst) : -1;
            run_instr(w, fst, mst, abort, r4(), c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multi_cycle_controller.md
# multi_cycle_controller

Multi-cycle control FSM that sequences the ARM datapath (PC, register file, extender, shifter, ALU with NZCV, shared instruction/data memory) for a single-port-memory implementation. It fetches each instruction, decodes it, evaluates its condition against an internal flags register, and steps the datapath through the execute, memory and writeback phases. It also owns the memory request handshake, which can stall. It sits beside the datapath and replaces the single-cycle combinational decoder.

## Interface
Parameters: none.

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- instr  in  32  instruction register contents; valid from DECODE onward
- alu_flags  in  4  ALU NZCV of the current cycle, [3]=N … [0]=V
- mem_ready  in  1  memory has completed the current request this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  request is a write; only asserted together with mem_req
- adr_src  out  1  memory address: 0=PC, 1=registered ALU result
- ir_write  out  1  latch read data into the instruction register
- pc_write  out  1  load PC from result
- reg_write  out  1  write result to Rd (instr[15:12])
- alu_src_a  out  1  0=Rn data, 1=PC
- alu_src_b  out  2  00=shifted Rm, 01=ext_imm, 10=constant 4
- result_src  out  2  00=registered ALU out, 01=data register, 10=ALU result direct
- imm_src  out  2  00=8-bit rotated imm, 01=12-bit imm, 10=24-bit branch offset
- reg_src  out  2  [0]=1 read port 1 = R15; [1]=1 read port 2 = Rd
- alu_ctl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR
- flags  out  4  registered NZCV
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction

## Operation
- States: FETCH, DECODE, EXECUTE, ALU_WB, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, BRANCH. Outputs are Moore, except that the FETCH completion strobes are qualified by mem_ready. Any output not listed for a state is 0.
- **FETCH:** mem_req=1, adr_src=0.
  - On mem_ready: ir_write=1, pc_write=1, alu_src_a=1, alu_src_b=10, alu_ctl=ADD, result_src=10, then go to DECODE.
  - Otherwise hold in FETCH.
- **DECODE:** alu_src_a=1, alu_src_b=10, alu_ctl=ADD, so PC+8 is presented for R15 reads.
  - Condition instr[31:28] is evaluated on `flags`: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL; 1111 means never.
  - Condition false, or op instr[27:26]=11: instr_done=1, go to FETCH (NOP).
  - op=00: go to EXECUTE. op=01: go to MEM_ADR. op=10: go to BRANCH.
- **EXECUTE:** alu_src_b = instr[25] ? 01 : 00, imm_src=00.
  - Command instr[24:21] maps to alu_ctl: 0100→ADD, 0010→SUB, 0000→AND, 1100→ORR, 1010 (CMP)→SUB. Any other command is unsupported.
  - flags ← alu_flags at the end of the cycle if instr[20]=1 or the command is CMP.
  - Next: ALU_WB. Unsupported commands go to ALU_WB with writeback suppressed.
- **ALU_WB:** result_src=00.
  - If Rd=15: pc_write=1. Otherwise: reg_write=1.
  - Both are suppressed for CMP and unsupported commands.
  - instr_done=1, go to FETCH.
- **MEM_ADR:** alu_src_b=01, imm_src=01, alu_ctl = instr[23] ? ADD : SUB.
  - instr[20]=1: go to MEM_RD. Otherwise: go to MEM_WR.
- **MEM_RD:** mem_req=1, adr_src=1. Hold until mem_ready, then go to MEM_WB.
- **MEM_WB:** result_src=01; pc_write=1 if Rd=15, else reg_write=1. instr_done=1, go to FETCH.
- **MEM_WR:** mem_req=1, mem_write=1, adr_src=1, reg_src=10. Hold until mem_ready, then instr_done=1 and go to FETCH.
- **BRANCH:** alu_src_a=1, alu_src_b=01, imm_src=10, alu_ctl=ADD, result_src=10, pc_write=1, instr_done=1, go to FETCH. The L bit is ignored (BL executes as B).

## Timing
- While reset=1: state←FETCH, flags←0000, all outputs are 0 (mem_req=0 included).
- The first cycle after reset deasserts is FETCH with mem_req=1.
- Reset during a memory wait abandons the access. No write strobe may be issued after reset is sampled.
- Cycle counts with mem_ready tied high:
  - data-processing: 4
  - LDR: 5
  - STR: 4
  - B: 3
  - condition-fail or NOP: 2
- Each cycle of mem_ready=0 in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- mem_req, adr_src and mem_write stay stable while waiting.
- mem_ready while mem_req=0 is ignored.
- flags change only at the end of EXECUTE; a condition in the next instruction's DECODE sees the new value.

## Test plan
- Reset held 3 cycles with mem_ready=1 → all outputs 0, flags=0000; first post-reset cycle has mem_req=1, adr_src=0.
- instr=0xE2821005 (ADD r1,r2,#5), mem_ready=1 → FETCH, DECODE, EXECUTE (alu_src_b=01, alu_ctl=000), ALU_WB (reg_write=1, result_src=00). instr_done fires in cycle 4.
- instr=0xE2533001 (SUBS), alu_flags=0100 in EXECUTE → flags=0100. Then 0x0A000001 (BEQ) → BRANCH with pc_write=1; with flags=0000 the BEQ instead retires after 2 cycles with no pc_write.
- instr=0xE5910004 (LDR), mem_ready low for 2 cycles in MEM_RD → mem_req/adr_src=1 held for 3 cycles, then MEM_WB with result_src=01, reg_write=1; 7 cycles total.
- instr=0xE5810008 (STR) → MEM_WR with mem_write=1, reg_src=10, reg_write never asserted. Reset asserted mid-wait → next cycle all outputs 0.
- instr=0xE1530004 (CMP) → flags updated, reg_write=0 and pc_write=0 in ALU_WB.
